// File: rtl/nsa_pkg.sv
// Shared types and helpers for the nibble-serial adder controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, nibble width constant, counter-width helper.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The nibble counter needs to hold 0..nibbles-1. It is kept at least one bit wide
    // so that a single-nibble build still has a legal counter vector.
    function automatic int cnt_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/adder4.sv
// 4-bit ripple adder used as the shared nibble datapath.
// Latency: combinational.
// Backpressure: none.
//
// Ports: A, B (4-bit operands), cin (carry in), S (4-bit sum), cout (carry out).
module adder4 (
    output logic [3:0] S,
    output logic       cout,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin
);

    logic [4:0] full;

    assign full = {1'b0, A} + {1'b0, B} + {4'b0000, cin};
    assign S    = full[3:0];
    assign cout = full[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder that reuses one adder4, LS nibble first, with a registered carry.
// Latency: out_valid rises WIDTH/4 cycles after the accept edge; min WIDTH/4+2 cycles per op.
// Backpressure: in_ready only in IDLE; DONE holds all outputs until out_ready; no queueing.
//
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a, b, cin;
//        out_valid/out_ready with sum, cout; busy (RUN or DONE);
//        ovf (signed overflow) only when NSA_OVERFLOW_EN is defined.
module nibble_serial_adder_ctrl
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16    // multiple of 4, >= 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef NSA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CW      = cnt_width(NIBBLES);

    state_t              state, state_nxt;
    logic [WIDTH-1:0]    a_sr, b_sr, sum_sr;
    logic                carry_q;
    logic [CW-1:0]       cnt;
    logic                last_nib;
    logic [NIBBLE_W-1:0] nib_s;
    logic                nib_cout;

`ifdef NSA_OVERFLOW_EN
    logic a_msb_q, b_msb_q, ovf_q;
`endif

    // Shared nibble datapath: always looks at the low nibbles of the operand shifters.
    adder4 u_adder4 (
        .S    (nib_s),
        .cout (nib_cout),
        .A    (a_sr[NIBBLE_W-1:0]),
        .B    (b_sr[NIBBLE_W-1:0]),
        .cin  (carry_q)
    );

    assign last_nib = (cnt == CW'(NIBBLES - 1));

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_nib)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
`ifdef NSA_OVERFLOW_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
`ifdef NSA_OVERFLOW_EN
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    // New nibble enters at the top; after NIBBLES shifts the sum is aligned.
                    // Shift/OR form keeps this legal for WIDTH == 4.
                    sum_sr  <= (sum_sr >> NIBBLE_W) | (WIDTH'(nib_s) << (WIDTH - NIBBLE_W));
                    a_sr    <= a_sr >> NIBBLE_W;
                    b_sr    <= b_sr >> NIBBLE_W;
                    carry_q <= nib_cout;
                    cnt     <= cnt + CW'(1);
`ifdef NSA_OVERFLOW_EN
                    // On the last nibble the adder's S[3] is the final sum MSB.
                    if (last_nib)
                        ovf_q <= (a_msb_q == b_msb_q) && (nib_s[NIBBLE_W-1] != a_msb_q);
`endif
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state or taken straight from registers.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_sr;
    assign cout      = carry_q;
`ifdef NSA_OVERFLOW_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl at WIDTH=16.
// Directed table, hand-written backpressure / mid-run reset sequences, random ops
// checked against an arithmetic reference model.
module tb_nibble_serial_adder_ctrl;

    localparam int W  = 16;
    localparam int NB = W / 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  sum;
    logic          cout;
    logic          busy;
`ifdef NSA_OVERFLOW_EN
    logic          ovf;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef NSA_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (s > 32767) || (s < -32768);
    endfunction

    // One full operation. Called with inputs freshly driven at posedge+1 while DUT is IDLE.
    // stall: DONE cycles with out_ready low. If nxt_v, next operands are presented during
    // the stall so they are picked up right after the release.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input int stall, input logic nxt_v,
                          input logic [W-1:0] na, input logic [W-1:0] nb, input logic nc);
        int waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            step();
            waited++;
        end
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; a = xa; b = xb; cin = xc; out_ready = 1'b0;
        step();                                 // E0
        in_valid = 1'b0;
        chk("run_busy", {31'd0, busy}, 32'd1);
        chk("run_in_ready", {31'd0, in_ready}, 32'd0);
        for (int k = 1; k <= NB; k++) begin
            step();                             // E1..E_NB
            chk("out_valid_timing", {31'd0, out_valid}, (k == NB) ? 32'd1 : 32'd0);
        end
        chk("sum", {16'd0, sum}, {16'd0, es});
        chk("cout", {31'd0, cout}, {31'd0, ec});
`ifdef NSA_OVERFLOW_EN
        chk("ovf", {31'd0, ovf}, {31'd0, eo});
`else
        if (eo === 1'bx) chk("ovf_model", 32'd0, 32'd1);
`endif
        if (nxt_v) begin
            in_valid = 1'b1; a = na; b = nb; cin = nc;
        end
        for (int k = 0; k < stall; k++) begin
            step();
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_sum", {16'd0, sum}, {16'd0, es});
            chk("stall_cout", {31'd0, cout}, {31'd0, ec});
        end
        out_ready = 1'b1;
        step();                                 // DONE -> IDLE
        out_ready = 1'b0;
        chk("release_valid", {31'd0, out_valid}, 32'd0);
        chk("release_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_sum_hold", {16'd0, sum}, {16'd0, es});
    endtask

    vec_t vecs[6];

    initial begin
        logic [W-1:0] ra, rb, qa, qb;
        logic         rc, qc;
        logic [W:0]   r;
        int           stall;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0};

        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
`ifdef NSA_OVERFLOW_EN
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        step();
        chk("idle_no_valid", {31'd0, out_valid}, 32'd0);

        // Directed table
        for (int i = 0; i < 6; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout,
                   vecs[i].exp_ovf, 0, 1'b0, '0, '0, 1'b0);

        // Backpressure: 3 stalled DONE cycles with new operands waiting, then those
        // operands go in one cycle after the release.
        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 3, 1'b1,
               16'hFFFF, 16'h0001, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, '0, '0, 1'b0);

        // Reset after E2 discards the operation.
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
        step();                                 // E0
        in_valid = 1'b0;
        step();                                 // E1
        step();                                 // E2
        rst = 1'b1;
        step();                                 // reset edge
        rst = 1'b0;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_sum", {16'd0, sum}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("midrst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0, '0, '0, 1'b0);

        // Random operations against the arithmetic model, random stalls; some chained
        // back-to-back through the pending-operand path.
        qa = W'($urandom); qb = W'($urandom); qc = 1'($urandom);
        for (int i = 0; i < 30; i++) begin
            ra = qa; rb = qb; rc = qc;
            qa = W'($urandom); qb = W'($urandom); qc = 1'($urandom);
            if (i % 5 == 0) begin ra = W'($urandom_range(0, 15)) << 12; rb = ~ra; end
            r = ref_add(ra, rb, rc);
            stall = int'($urandom_range(0, 2));
            run_op(ra, rb, rc, r[W-1:0], r[W], ref_ovf(ra, rb, rc), stall,
                   1'($urandom_range(0, 1)), qa, qb, qc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog");
    end

endmodule
